// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - state encoding and sensor limits for the DHT11 read scheduler
package dht11_pkg;

  // State encoding; OCIOSO must stay 0 so db_estado resets to 0
  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    DISPARA = 4'd1,
    GUARDA  = 4'd2,
    AGUARDA = 4'd3,
    ACEITA  = 4'd4,
    FALHOU  = 4'd5
  } estado_t;

  // Integer-byte limits the DHT11 can physically report
  localparam logic [7:0] HUM_MAX  = 8'd100;
  localparam logic [7:0] TEMP_MAX = 8'd60;

  // True when a reading is outside the sensor's physical range
  function automatic logic fora_de_faixa(input logic [15:0] umid, input logic [15:0] temp);
    return (umid[15:8] > HUM_MAX) || (temp[15:8] > TEMP_MAX);
  endfunction

endpackage

// File: rtl/dht11_scheduler.sv
// rtl/dht11_scheduler.sv - DHT11 read scheduler; optional range check via DHT_RANGE_CHECK_EN
module dht11_scheduler
  import dht11_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned MIN_GAP_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        habilita,
  input  logic        medir,
  output logic        dht_start,
  input  logic        dht_pronto,
  input  logic        dht_erro,
  input  logic [15:0] dht_temperatura,
  input  logic [15:0] dht_umidade,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        valido,
  output logic        novo_dado,
  output logic        falha,
  output logic [7:0]  contagem_erros,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam logic [31:0] PERIOD  = 32'(PERIOD_CYCLES);
  localparam logic [31:0] MIN_GAP = 32'(MIN_GAP_CYCLES);
  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAX_RET = 8'(MAX_RETRIES);

  estado_t     estado;
  logic [31:0] gap;
  logic [31:0] tcount;
  logic [7:0]  retries;
  logic        pending;
  logic        request;
  logic        disparar;
  logic        fora;
  logic        falha_leitura;

  assign request  = medir | pending | (habilita & (gap >= PERIOD));
  assign disparar = (estado == OCIOSO) & request & (gap >= MIN_GAP);

`ifdef DHT_RANGE_CHECK_EN
  assign fora = fora_de_faixa(dht_umidade, dht_temperatura);
`else
  assign fora = 1'b0;
`endif

  // erro wins over pronto; an out-of-range pronto counts as erro
  assign falha_leitura = dht_erro | (dht_pronto & fora) | (tcount == TIMEOUT - 32'd1);

  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

  // Gap counter: includes the start cycle itself, so start-to-start spacing equals the threshold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap <= 32'd0;
    end else if (disparar) begin
      gap <= 32'd1;
    end else if (gap < PERIOD) begin
      gap <= gap + 32'd1;
    end
  end

  // Read sequencing FSM with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado         <= OCIOSO;
      dht_start      <= 1'b0;
      novo_dado      <= 1'b0;
      temperatura    <= 16'd0;
      umidade        <= 16'd0;
      valido         <= 1'b0;
      falha          <= 1'b0;
      contagem_erros <= 8'd0;
      retries        <= 8'd0;
      pending        <= 1'b0;
      tcount         <= 32'd0;
    end else begin
      dht_start <= 1'b0;
      novo_dado <= 1'b0;
      if (medir) pending <= 1'b1;
      case (estado)
        OCIOSO: begin
          if (disparar) begin
            dht_start <= 1'b1;
            estado    <= DISPARA;
          end
        end
        DISPARA: begin
          pending <= medir;
          tcount  <= 32'd0;
          estado  <= GUARDA;
        end
        GUARDA: begin
          estado <= AGUARDA;
        end
        AGUARDA: begin
          tcount <= tcount + 32'd1;
          if (falha_leitura) estado <= FALHOU;
          else if (dht_pronto) estado <= ACEITA;
        end
        ACEITA: begin
          temperatura <= dht_temperatura;
          umidade     <= dht_umidade;
          novo_dado   <= 1'b1;
          valido      <= 1'b1;
          falha       <= 1'b0;
          retries     <= 8'd0;
          estado      <= OCIOSO;
        end
        FALHOU: begin
          if (contagem_erros != 8'hFF) contagem_erros <= contagem_erros + 8'd1;
          if (retries < MAX_RET) begin
            retries <= retries + 8'd1;
            pending <= 1'b1;
          end else begin
            falha   <= 1'b1;
            retries <= 8'd0;
          end
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// tb/tb_dht11_scheduler.sv - scoreboard bench for dht11_scheduler with a modelled driver
module tb_dht11_scheduler;

  localparam int PERIOD  = 200;
  localparam int MIN_GAP = 100;
  localparam int TIMEOUT = 50;
  localparam int MAX_RET = 2;
  localparam int DELAY   = 20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        habilita = 1'b0;
  logic        medir = 1'b0;
  logic        dht_start;
  logic        dht_pronto = 1'b0;
  logic        dht_erro = 1'b0;
  logic [15:0] dht_temperatura = 16'd0;
  logic [15:0] dht_umidade = 16'd0;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        valido;
  logic        novo_dado;
  logic        falha;
  logic [7:0]  contagem_erros;
  logic        ocupado;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  dht11_scheduler #(
    .PERIOD_CYCLES(PERIOD),
    .MIN_GAP_CYCLES(MIN_GAP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES(MAX_RET)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .habilita(habilita),
    .medir(medir),
    .dht_start(dht_start),
    .dht_pronto(dht_pronto),
    .dht_erro(dht_erro),
    .dht_temperatura(dht_temperatura),
    .dht_umidade(dht_umidade),
    .temperatura(temperatura),
    .umidade(umidade),
    .valido(valido),
    .novo_dado(novo_dado),
    .falha(falha),
    .contagem_erros(contagem_erros),
    .ocupado(ocupado),
    .db_estado(db_estado)
  );

  // kind: 0 = never responds, 1 = pronto with data, 2 = erro
  typedef struct { int kind; logic [15:0] hum; logic [15:0] temp; } resp_t;
  typedef struct { logic [15:0] hum; logic [15:0] temp; } exp_t;

  resp_t resp_q[$];
  exp_t  exp_q[$];
  int    starts[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    novo_cnt = 0;
  int    busy_cnt = 0;
  int    drv_cnt = 0;
  resp_t drv_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Driver model: clears flags on start, answers DELAY cycles later
  always @(negedge clock) begin
    if (!reset_n) begin
      drv_cnt = 0;
    end else if (dht_start) begin
      dht_pronto = 1'b0;
      dht_erro   = 1'b0;
      if (resp_q.size() > 0) drv_r = resp_q.pop_front();
      else drv_r = '{0, 16'h0, 16'h0};
      drv_cnt = DELAY;
    end else if (drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) begin
        case (drv_r.kind)
          1: begin
            dht_umidade     = drv_r.hum;
            dht_temperatura = drv_r.temp;
            dht_pronto      = 1'b1;
          end
          2: dht_erro = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Monitor: records starts, busy cycles, and checks each novo_dado against the scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (dht_start) starts.push_back(cyc);
      if (ocupado) busy_cnt++;
      if (novo_dado) begin
        novo_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected novo_dado", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("novo umidade", umidade, e.hum);
          check("novo temperatura", temperatura, e.temp);
          check("novo valido", valido, 1);
        end
      end
    end
  end

  task automatic ncyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_medir();
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
  endtask

  task automatic queue_ok(input logic [15:0] h, input logic [15:0] t);
    resp_q.push_back('{1, h, t});
    exp_q.push_back('{h, t});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, n0, b0, c0;

    // Reset state
    ncyc(3);
    check("rst temperatura", temperatura, 0);
    check("rst umidade", umidade, 0);
    check("rst valido", valido, 0);
    check("rst falha", falha, 0);
    check("rst contagem", contagem_erros, 0);
    check("rst ocupado", ocupado, 0);
    check("rst dht_start", dht_start, 0);

    // 1: early medir waits for the power-up gap, first start on edge 101
    reset_n = 1'b1;
    r0 = cyc;
    s0 = starts.size();
    queue_ok(16'h3700, 16'h1900);
    ncyc(9);
    pulse_medir();
    ncyc(200);
    check("t1 start count", starts.size() - s0, 1);
    if (starts.size() > s0) check("t1 start latency", starts[s0] - r0, 101);
    check("t1 valido", valido, 1);
    check("t1 umidade", umidade, 16'h3700);
    check("t1 temperatura", temperatura, 16'h1900);
    check("t1 novo count", novo_cnt, 1);
    ncyc(100);

    // 2: periodic mode, one start every 200 cycles over 1000 cycles
    s0 = starts.size();
    n0 = novo_cnt;
    for (int i = 0; i < 5; i++) queue_ok(16'h3800 + 16'(i), 16'h1800 + 16'(i));
    habilita = 1'b1;
    ncyc(1000);
    habilita = 1'b0;
    ncyc(100);
    check("t2 start count", starts.size() - s0, 5);
    for (int i = 1; i < 5; i++)
      if (starts.size() > s0 + i) check("t2 spacing", starts[s0+i] - starts[s0+i-1], 200);
    check("t2 novo count", novo_cnt - n0, 5);

    // 3: two errors then success
    s0 = starts.size();
    resp_q.push_back('{2, 16'h0, 16'h0});
    resp_q.push_back('{2, 16'h0, 16'h0});
    queue_ok(16'h3a00, 16'h1a00);
    pulse_medir();
    ncyc(350);
    check("t3 start count", starts.size() - s0, 3);
    for (int i = 1; i < 3; i++)
      if (starts.size() > s0 + i) check("t3 spacing>=gap", 32'(starts[s0+i] - starts[s0+i-1] >= MIN_GAP), 1);
    check("t3 contagem", contagem_erros, 2);
    check("t3 falha", falha, 0);
    check("t3 umidade", umidade, 16'h3a00);
    check("t3 temperatura", temperatura, 16'h1a00);

    // 4: sensor never answers; three 50-cycle timeouts, busy 53 cycles each
    s0 = starts.size();
    b0 = busy_cnt;
    for (int i = 0; i < 3; i++) resp_q.push_back('{0, 16'h0, 16'h0});
    pulse_medir();
    ncyc(350);
    check("t4 start count", starts.size() - s0, 3);
    check("t4 busy cycles", busy_cnt - b0, 159);
    check("t4 falha", falha, 1);
    check("t4 contagem", contagem_erros, 5);
    check("t4 umidade kept", umidade, 16'h3a00);
    check("t4 temperatura kept", temperatura, 16'h1a00);
    check("t4 valido", valido, 1);

    // 5: three medir pulses mid-read merge into one extra start
    s0 = starts.size();
    n0 = novo_cnt;
    queue_ok(16'h3b00, 16'h1b00);
    queue_ok(16'h3c00, 16'h1c00);
    c0 = cyc;
    pulse_medir();
    ncyc(4);
    pulse_medir();
    ncyc(2);
    pulse_medir();
    ncyc(2);
    pulse_medir();
    ncyc(300);
    check("t5 start count", starts.size() - s0, 2);
    if (starts.size() > s0) check("t5 medir latency", starts[s0] - c0, 1);
    if (starts.size() > s0 + 1) check("t5 spacing", starts[s0+1] - starts[s0], 100);
    check("t5 novo count", novo_cnt - n0, 2);
    check("t5 falha cleared", falha, 0);
    check("t5 contagem", contagem_erros, 5);

    // 5b: reset during AGUARDA clears everything at once
    resp_q.push_back('{1, 16'h7700, 16'h7700});
    pulse_medir();
    ncyc(5);
    check("t5b in AGUARDA", db_estado, 3);
    reset_n = 1'b0;
    #1;
    check("t5b temperatura", temperatura, 0);
    check("t5b umidade", umidade, 0);
    check("t5b valido", valido, 0);
    check("t5b falha", falha, 0);
    check("t5b contagem", contagem_erros, 0);
    check("t5b ocupado", ocupado, 0);
    check("t5b db_estado", db_estado, 0);
    check("t5b dht_start", dht_start, 0);
    check("t5b novo_dado", novo_dado, 0);
    ncyc(3);

    // 6: out-of-range humidity (101 %)
    reset_n = 1'b1;
    r0 = cyc;
    s0 = starts.size();
    resp_q.push_back('{1, 16'h6500, 16'h1900});
`ifdef DHT_RANGE_CHECK_EN
    queue_ok(16'h3000, 16'h1800);
`else
    exp_q.push_back('{16'h6500, 16'h1900});
`endif
    ncyc(9);
    pulse_medir();
    ncyc(150);
`ifdef DHT_RANGE_CHECK_EN
    check("t6 rejected valido", valido, 0);
    check("t6 rejected umidade", umidade, 0);
    check("t6 rejected contagem", contagem_erros, 1);
`else
    check("t6 accepted valido", valido, 1);
    check("t6 accepted umidade", umidade, 16'h6500);
    check("t6 accepted contagem", contagem_erros, 0);
`endif
    ncyc(150);
`ifdef DHT_RANGE_CHECK_EN
    check("t6 start count", starts.size() - s0, 2);
    check("t6 retry umidade", umidade, 16'h3000);
    check("t6 retry contagem", contagem_erros, 1);
`else
    check("t6 start count", starts.size() - s0, 1);
    check("t6 final umidade", umidade, 16'h6500);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    check("responses drained", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
